// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_pkg
//  Description : Shared types, seeds and the MIRROR step function for the
//                16-LED pattern sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    typedef enum logic [1:0] {
        MODE_MIRROR = 2'd0,
        MODE_ROTATE = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        LOAD = 2'd2
    } state_t;

    localparam logic [15:0] c_SEED_MIRROR = 16'h8001;
    localparam logic [15:0] c_SEED_ROTATE = 16'h0001;
    localparam logic [15:0] c_SEED_BOUNCE = 16'h0001;
    localparam logic [15:0] c_SEED_BLINK  = 16'hFFFF;

    // Converging pair of bits; anything off the 8-step cycle re-enters at the seed.
    function automatic logic [15:0] mirror_next(input logic [15:0] p);
        logic [15:0] r;
        case (p)
            16'h8001: r = 16'h4002;
            16'h4002: r = 16'h2004;
            16'h2004: r = 16'h1008;
            16'h1008: r = 16'h0810;
            16'h0810: r = 16'h0420;
            16'h0420: r = 16'h0240;
            16'h0240: r = 16'h0180;
            default:  r = 16'h8001;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : led_prescaler
//  Description : Step-period counter; pulses tick when cnt reaches the
//                speed-scaled period.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_prescaler #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] speed,
    output logic       tick
);

    logic [31:0] r_cnt;
    logic [31:0] w_period_m1;

    // A >= compare lets a shortened period fire immediately on a speed change.
    assign w_period_m1 = (32'(TICK_DIV) >> speed) - 32'd1;
    assign tick        = en && (r_cnt >= w_period_m1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 32'd0;
        end else if (clr) begin
            r_cnt <= 32'd0;
        end else if (en) begin
            r_cnt <= tick ? 32'd0 : r_cnt + 32'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : led_seq_ctrl
//  Description : 16-LED pattern sequencer with selectable mode, step rate
//                and pause; drives active-low LED pins.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_seq_ctrl
    import led_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode_req,
    input  logic        mode_vld,
    input  logic [1:0]  speed,
    input  logic        pause,
    output logic [15:0] led,
    output logic [1:0]  mode_cur,
    output logic        step
);

    state_t      r_state;
    state_t      w_state_nxt;
    mode_t       r_mode;
    logic [15:0] r_pattern;
    logic [15:0] w_pattern_nxt;
    logic        r_dir_left;
    logic        w_dir_nxt;
    logic        r_step;
    logic        w_en;
    logic        w_clr;
    logic        w_tick;

    led_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (w_en),
        .clr   (w_clr),
        .speed (speed),
        .tick  (w_tick)
    );

    // A commit strobe suppresses counting so no step can land in that cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = (r_state == LOAD);
        w_en        = (r_state == RUN) && !pause && !mode_vld;
        if (mode_vld) begin
            w_state_nxt = LOAD;
        end else begin
            case (r_state)
                RUN:     w_state_nxt = pause ? HOLD : RUN;
                HOLD:    w_state_nxt = pause ? HOLD : RUN;
                LOAD:    w_state_nxt = pause ? HOLD : RUN;
                default: w_state_nxt = RUN;
            endcase
        end
    end

    always_comb begin
        w_pattern_nxt = r_pattern;
        w_dir_nxt     = r_dir_left;
        if (w_clr) begin
            w_dir_nxt = 1'b1;
            case (r_mode)
                MODE_MIRROR: w_pattern_nxt = c_SEED_MIRROR;
                MODE_ROTATE: w_pattern_nxt = c_SEED_ROTATE;
                MODE_BOUNCE: w_pattern_nxt = c_SEED_BOUNCE;
                default:     w_pattern_nxt = c_SEED_BLINK;
            endcase
        end else if (w_tick) begin
            case (r_mode)
                MODE_MIRROR: w_pattern_nxt = mirror_next(r_pattern);
                MODE_ROTATE: w_pattern_nxt = {r_pattern[14:0], r_pattern[15]};
                MODE_BOUNCE: begin
                    // Turn around at an end so each end is shown exactly once.
                    if (r_dir_left) begin
                        if (r_pattern == 16'h8000) begin
                            w_pattern_nxt = r_pattern >> 1;
                            w_dir_nxt     = 1'b0;
                        end else begin
                            w_pattern_nxt = r_pattern << 1;
                        end
                    end else begin
                        if (r_pattern == 16'h0001) begin
                            w_pattern_nxt = r_pattern << 1;
                            w_dir_nxt     = 1'b1;
                        end else begin
                            w_pattern_nxt = r_pattern >> 1;
                        end
                    end
                end
                default: w_pattern_nxt = (r_pattern == 16'hFFFF) ? 16'h0000 : 16'hFFFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_mode     <= MODE_MIRROR;
            r_pattern  <= c_SEED_MIRROR;
            r_dir_left <= 1'b1;
            r_step     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pattern  <= w_pattern_nxt;
            r_dir_left <= w_dir_nxt;
            r_step     <= w_tick;
            if (mode_vld) begin
                r_mode <= mode_t'(mode_req);
            end
        end
    end

    assign led      = ~r_pattern;
    assign mode_cur = r_mode;
    assign step     = r_step;

endmodule
`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_seq_ctrl
//  Description : Scoreboard bench for led_seq_ctrl with TICK_DIV = 8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_seq_ctrl;

    logic        clk;
    logic        rst;
    logic [1:0]  mode_req;
    logic        mode_vld;
    logic [1:0]  speed;
    logic        pause;
    logic [15:0] led;
    logic [1:0]  mode_cur;
    logic        step;

    typedef struct {
        logic [15:0] pat;
        int          gap;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   ref_cyc = 0;
    int   last_step_cyc = 0;
    bit   strict  = 1'b1;

    led_seq_ctrl #(
        .TICK_DIV (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode_req (mode_req),
        .mode_vld (mode_vld),
        .speed    (speed),
        .pause    (pause),
        .led      (led),
        .mode_cur (mode_cur),
        .step     (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] p, input int g);
        exp_t e;
        e.pat = p;
        e.gap = g;
        sb_q.push_back(e);
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            tick1();
            n++;
        end
        if (sb_q.size() != 0) begin
            check("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    task automatic wait_until(input int target);
        int n = 0;
        while (cyc < target && n < 1000) begin
            tick1();
            n++;
        end
        if (cyc != target) check("sync", cyc, target);
    endtask

    // Pattern compared as active-high; gap is clock edges since the last reference.
    always @(negedge clk) begin : mon
        exp_t        e;
        logic [15:0] p;
        if (step === 1'b1) begin
            p = ~led;
            if (sb_q.size() == 0) begin
                if (strict) check("unexp_step", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("pattern", p, e.pat);
                check("gap", cyc - ref_cyc, e.gap);
            end
            ref_cyc       = cyc;
            last_step_cyc = cyc;
        end
    end

    initial begin
        int r0;
        rst      = 1'b1;
        mode_vld = 1'b0;
        mode_req = 2'd0;
        speed    = 2'd0;
        pause    = 1'b0;

        // Reset state and MIRROR cycle at speed 0
        repeat (2) tick1();
        check("rst_led", led, 16'h7FFE);
        check("rst_mode", mode_cur, 2'd0);
        check("rst_step", step, 1'b0);
        rst     = 1'b0;
        ref_cyc = cyc;
        push(16'h4002, 8); push(16'h2004, 8); push(16'h1008, 8); push(16'h0810, 8);
        push(16'h0420, 8); push(16'h0240, 8); push(16'h0180, 8); push(16'h8001, 8);
        wait_drain();

        // Commit ROTATE in the cycle cnt sits at 7
        wait_until(last_step_cyc + 7);
        mode_req = 2'd1;
        mode_vld = 1'b1;
        tick1();
        mode_vld = 1'b0;
        check("vld_mode", mode_cur, 2'd1);
        check("vld_noadv", led, 16'h7FFE);
        check("vld_nostep", step, 1'b0);
        tick1();
        check("rot_seed", led, 16'hFFFE);
        ref_cyc = cyc;
        push(16'h0002, 8);
        push(16'h0004, 8);
        wait_drain();

        // Pause for 20 cycles after 3 counted cycles
        wait_until(last_step_cyc + 3);
        pause = 1'b1;
        repeat (20) tick1();
        check("pause_led", led, 16'hFFFB);
        check("pause_step", step, 1'b0);
        pause   = 1'b0;
        ref_cyc = cyc;
        push(16'h0008, 6);
        wait_drain();

        // BOUNCE at period 1
        speed    = 2'd3;
        mode_req = 2'd2;
        mode_vld = 1'b1;
        ref_cyc  = cyc;
        push(16'h0002, 3);
        for (int i = 2; i < 16; i++) push(16'h0001 << i, 1);
        for (int i = 14; i >= 0; i--) push(16'h0001 << i, 1);
        push(16'h0002, 1);
        tick1();
        mode_vld = 1'b0;
        check("bnc_mode", mode_cur, 2'd2);
        wait_drain();

        // Reset mid-BOUNCE together with a commit strobe
        strict   = 1'b0;
        rst      = 1'b1;
        mode_vld = 1'b1;
        mode_req = 2'd2;
        speed    = 2'd0;
        tick1();
        check("rst2_led", led, 16'h7FFE);
        check("rst2_mode", mode_cur, 2'd0);
        check("rst2_step", step, 1'b0);
        rst      = 1'b0;
        mode_vld = 1'b0;
        tick1();
        check("rst2_mode_hold", mode_cur, 2'd0);
        check("rst2_led_hold", led, 16'h7FFE);

        // BLINK, speed change 0 -> 2 while cnt = 6
        mode_req = 2'd3;
        mode_vld = 1'b1;
        r0       = cyc;
        tick1();
        mode_vld = 1'b0;
        wait_until(r0 + 2);
        check("blink_seed", led, 16'h0000);
        wait_until(r0 + 8);
        speed   = 2'd2;
        ref_cyc = cyc;
        strict  = 1'b1;
        push(16'h0000, 1);
        push(16'hFFFF, 2);
        push(16'h0000, 2);
        push(16'hFFFF, 2);
        wait_drain();
        strict = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
